// File: rtl/conv_ctrl.sv
// Sequencer for one convolve MAC lane: clear, tap fetch, drain, saturate, offer result.
// Latency: KERNEL_TAPS+MAC_LAT+4 cycles per output with out_ready held high.
// Backpressure: holds in OUT with out_valid/conv_en_sat high and MAC clock gated until out_ready.
module conv_ctrl #(
  parameter int KERNEL_TAPS = 9,
  parameter int NUM_OUT     = 16,
  parameter int ADDR_W      = 8,
  parameter int SIG_STRIDE  = 1,
  parameter int MAC_LAT     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] sig_base,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] sig_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic              conv_clken,
  output logic              conv_s_convout,
  output logic              conv_en_sat,
  output logic              conv_en_mult_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_idx
);

  // DRAIN covers the 1-cycle buffer read latency plus the MAC pipeline.
  localparam int DRAIN_CYC = MAC_LAT + 1;
  localparam int CNT_MAX   = (KERNEL_TAPS > DRAIN_CYC) ? KERNEL_TAPS : DRAIN_CYC;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  TAP_LAST   = CNT_W'(KERNEL_TAPS - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
  localparam logic [15:0]       IDX_LAST   = 16'(NUM_OUT - 1);
  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(SIG_STRIDE);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_DRAIN, S_SAT, S_OUT, S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_sig_addr;
  logic [ADDR_W-1:0] r_wgt_addr;
  logic [15:0]       r_out_idx;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic              r_clken;
  logic              r_clr;
  logic              r_sat;
  logic              r_valid;

  // Single FSM: state, counters and every output strobe are registered together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_row_base <= '0;
      r_sig_addr <= '0;
      r_wgt_addr <= '0;
      r_out_idx  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_clken    <= 1'b0;
      r_clr      <= 1'b0;
      r_sat      <= 1'b0;
      r_valid    <= 1'b0;
    end else if (abort) begin
      // Cancel drops every strobe, including the clken owed to the last read.
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sig_addr <= '0;
      r_wgt_addr <= '0;
      r_out_idx  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_clken    <= 1'b0;
      r_clr      <= 1'b0;
      r_sat      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      // MAC enable tracks read data, which arrives one cycle after the strobe.
      r_clken <= r_rd_en;
      r_done  <= 1'b0;
      r_clr   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row_base <= sig_base;
            r_out_idx  <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_clr      <= 1'b1;
            r_state    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_rd_en    <= 1'b1;
          r_sig_addr <= r_row_base;
          r_wgt_addr <= '0;
          r_cnt      <= '0;
          r_state    <= S_FETCH;
        end
        S_FETCH: begin
          if (r_cnt == TAP_LAST) begin
            r_rd_en <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_sig_addr <= r_sig_addr + 1'b1;
            r_wgt_addr <= r_wgt_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_cnt == DRAIN_LAST) begin
            r_cnt   <= '0;
            r_sat   <= 1'b1;
            r_state <= S_SAT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SAT: begin
          r_valid <= 1'b1;
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
            if (r_out_idx == IDX_LAST) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_out_idx  <= r_out_idx + 16'd1;
              r_row_base <= r_row_base + STRIDE;
              r_clr      <= 1'b1;
              r_state    <= S_CLEAR;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign rd_en          = r_rd_en;
  assign sig_addr       = r_sig_addr;
  assign wgt_addr       = r_wgt_addr;
  assign conv_clken     = r_clken;
  assign conv_s_convout = r_clr;
  assign conv_en_sat    = r_sat;
  assign conv_en_mult_r = 1'b0;
  assign out_valid      = r_valid;
  assign out_idx        = r_out_idx;

endmodule
